// File: rtl/alien_bomb.sv
// Alien return fire: drops one bomb at a time from the firing alien, steps it down
// once per video frame, and tracks ship collisions, lives and game over.
module alien_bomb #(
    parameter logic [10:0] BOTTOM_EDGE       = 11'd480,
    parameter logic [10:0] SHIP_TOP          = 11'd420,
    parameter logic [10:0] SHIP_BOTTOM       = 11'd430,
    parameter logic [10:0] SHIP_HALF_LEN     = 11'd20,
    parameter logic [10:0] ALIEN_HALF_HEIGHT = 11'd8,
    parameter logic [10:0] BOMB_HALF_W       = 11'd1,
    parameter logic [10:0] BOMB_HALF_H       = 11'd4,
    parameter logic [10:0] BOMB_SPEED        = 11'd2,
    parameter logic [6:0]  MIN_DELAY         = 7'd30,
    parameter logic [5:0]  HIT_FRAMES        = 6'd30,
    parameter logic [1:0]  INIT_LIVES        = 2'd3,
    parameter logic [7:0]  COLOR_BOMB        = 8'b00111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [1:0]  mode,
    input  logic [10:0] xCoord,
    input  logic [10:0] yCoord,
    input  logic [10:0] alien_xCoord,
    input  logic [10:0] alien_yCoord,
    input  logic [10:0] spaceship_xCoord,
    output logic [7:0]  rgb_bomb,
    output logic        is_bomb,
    output logic        ship_hit,
    output logic        ship_flash,
    output logic [1:0]  lives,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, FALLING, HIT, OVER} state_t;

    state_t      state;
    logic        f_now, f_q;
    logic [7:0]  lfsr;
    logic [6:0]  delay;
    logic [10:0] bomb_x, bomb_y;
    logic [5:0]  flash_cnt;

    logic        tick, run, reinit, hit_now, miss_now;
    logic [6:0]  idle_delay;

    // Edge-detect the (0,0) pixel so the tick is one clk wide whatever the pixel rate.
    assign tick   = f_now & ~f_q;
    assign run    = tick & (mode == 2'd2);
    assign reinit = rst | restart | ~mode[1];

    assign idle_delay = MIN_DELAY + {1'b0, lfsr[5:0]};

    // All compares in addition form so nothing underflows near the screen edge.
    assign hit_now = (bomb_y + BOMB_HALF_H >= SHIP_TOP)
                  && (bomb_y <= SHIP_BOTTOM + BOMB_HALF_H)
                  && (bomb_x + SHIP_HALF_LEN >= spaceship_xCoord)
                  && (bomb_x <= spaceship_xCoord + SHIP_HALF_LEN);
    assign miss_now = (bomb_y + BOMB_HALF_H >= BOTTOM_EDGE);

    assign is_bomb = (state == FALLING)
                  && (xCoord + BOMB_HALF_W >= bomb_x) && (xCoord <= bomb_x + BOMB_HALF_W)
                  && (yCoord + BOMB_HALF_H >= bomb_y) && (yCoord <= bomb_y + BOMB_HALF_H);

    assign rgb_bomb   = COLOR_BOMB;
    assign ship_flash = (state == HIT);
    assign game_over  = (state == OVER);

    always_ff @(posedge clk) begin
        if (rst) begin
            f_now <= 1'b0;
            f_q   <= 1'b0;
        end else begin
            f_now <= (xCoord == 11'd0) && (yCoord == 11'd0);
            f_q   <= f_now;
        end
    end

    // Only rst reloads the seed, so restarts keep drawing fresh launch delays.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 8'hA5;
        else if (run && !reinit)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_ff @(posedge clk) begin
        ship_hit <= 1'b0;
        if (reinit) begin
            state     <= IDLE;
            delay     <= MIN_DELAY;
            lives     <= INIT_LIVES;
            bomb_x    <= 11'd0;
            bomb_y    <= 11'd0;
            flash_cnt <= 6'd0;
        end else if (run) begin
            case (state)
                IDLE: begin
                    if (delay != 7'd0) begin
                        delay <= delay - 7'd1;
                    end else if (alien_xCoord != 11'd0) begin
                        bomb_x <= alien_xCoord;
                        bomb_y <= alien_yCoord + ALIEN_HALF_HEIGHT + BOMB_HALF_H;
                        state  <= FALLING;
                    end
                end
                FALLING: begin
                    if (hit_now) begin
                        ship_hit  <= 1'b1;
                        if (lives != 2'd0)
                            lives <= lives - 2'd1;
                        flash_cnt <= HIT_FRAMES;
                        state     <= HIT;
                    end else if (miss_now) begin
                        delay <= idle_delay;
                        state <= IDLE;
                    end else begin
                        bomb_y <= bomb_y + BOMB_SPEED;
                    end
                end
                HIT: begin
                    if (flash_cnt <= 6'd1) begin
                        flash_cnt <= 6'd0;
                        if (lives == 2'd0) begin
                            state <= OVER;
                        end else begin
                            delay <= idle_delay;
                            state <= IDLE;
                        end
                    end else begin
                        flash_cnt <= flash_cnt - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alien_bomb.sv
// Frame-stepped bench for alien_bomb: a frame-level reference model feeds a
// scoreboard queue; bomb pixel boundaries come from a vector table.
module tb_alien_bomb;

    logic        clk = 1'b0;
    logic        rst, restart;
    logic [1:0]  mode;
    logic [10:0] xCoord, yCoord, alien_xCoord, alien_yCoord, spaceship_xCoord;
    logic [7:0]  rgb_bomb;
    logic        is_bomb, ship_hit, ship_flash, game_over;
    logic [1:0]  lives;

    alien_bomb dut (
        .clk(clk), .rst(rst), .restart(restart), .mode(mode),
        .xCoord(xCoord), .yCoord(yCoord),
        .alien_xCoord(alien_xCoord), .alien_yCoord(alien_yCoord),
        .spaceship_xCoord(spaceship_xCoord),
        .rgb_bomb(rgb_bomb), .is_bomb(is_bomb), .ship_hit(ship_hit),
        .ship_flash(ship_flash), .lives(lives), .game_over(game_over)
    );

    always #5 clk = ~clk;

    localparam int S_IDLE = 0, S_FALL = 1, S_HIT = 2, S_OVER = 3;

    typedef struct {
        int lives;
        bit flash;
        bit over;
        bit hit;
        bit active;
        int bx;
        int by;
    } exp_t;

    typedef struct {
        int dx;
        int dy;
        bit exp_bomb;
    } pix_t;

    exp_t sbq[$];
    pix_t tbl[12];

    int n_chk = 0, n_fail = 0, hits_seen = 0;

    // Reference model state, advanced once per frame
    int m_st, m_delay, m_lives, m_bx, m_by, m_flash;
    bit m_hit;
    logic [7:0] m_lfsr;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic cyc(input int x, input int y);
        @(posedge clk);
        #1;
        xCoord = 11'(x);
        yCoord = 11'(y);
        @(negedge clk);
    endtask

    task automatic model_reinit();
        m_st = S_IDLE; m_delay = 30; m_lives = 3;
        m_bx = 0; m_by = 0; m_flash = 0;
    endtask

    task automatic model_step(input logic [1:0] md, input bit rs);
        logic [7:0] cur;
        m_hit = 1'b0;
        if (rs || md < 2) model_reinit();
        if (md != 2) return;
        cur = m_lfsr;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'b1011_1000)};
        case (m_st)
            S_IDLE:
                if (m_delay > 0) m_delay--;
                else if (alien_xCoord != 0) begin
                    m_bx = alien_xCoord;
                    m_by = alien_yCoord + 12;
                    m_st = S_FALL;
                end
            S_FALL:
                if (m_by + 4 >= 420 && m_by <= 434 &&
                    m_bx + 20 >= spaceship_xCoord && m_bx <= spaceship_xCoord + 20) begin
                    m_hit = 1'b1;
                    if (m_lives > 0) m_lives--;
                    m_flash = 30;
                    m_st = S_HIT;
                end else if (m_by + 4 >= 480) begin
                    m_st = S_IDLE;
                    m_delay = 30 + int'(cur[5:0]);
                end else m_by += 2;
            S_HIT: begin
                m_flash--;
                if (m_flash == 0) begin
                    if (m_lives == 0) m_st = S_OVER;
                    else begin
                        m_st = S_IDLE;
                        m_delay = 30 + int'(cur[5:0]);
                    end
                end
            end
            default: ;
        endcase
    endtask

    // One video frame: (0,0) pixel, tick cycle, then three probe pixels.
    task automatic frame(input logic [1:0] md, input bit rs = 1'b0);
        exp_t e;
        int px, py;
        @(posedge clk);
        #1;
        mode = md; restart = rs; xCoord = 0; yCoord = 0;
        model_step(md, rs);
        sbq.push_back('{m_lives, (m_st == S_HIT), (m_st == S_OVER), m_hit,
                        (m_st == S_FALL), m_bx, m_by});
        @(negedge clk);
        cyc(7, 7);
        restart = 1'b0;
        e = sbq.pop_front();
        if (e.active) begin px = e.bx; py = e.by; end
        else begin px = 320; py = 300; end
        cyc(px, py);
        chk("ship_hit", int'(ship_hit), int'(e.hit));
        if (ship_hit) hits_seen++;
        chk("is_bomb_centre", int'(is_bomb), int'(e.active));
        chk("lives", int'(lives), e.lives);
        chk("ship_flash", int'(ship_flash), int'(e.flash));
        chk("game_over", int'(game_over), int'(e.over));
        cyc(px, py + 5);
        chk("is_bomb_below", int'(is_bomb), 0);
        chk("ship_hit_width", int'(ship_hit), 0);
        cyc(px, py - 5);
        chk("is_bomb_above", int'(is_bomb), 0);
    endtask

    task automatic run_until_model(input int st, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            frame(2'd2);
            if (m_st == st) begin n = i; break; end
        end
    endtask

    initial begin
        int n;
        tbl = '{'{0, 0, 1}, '{-1, 0, 1}, '{1, 0, 1}, '{-2, 0, 0},
                '{2, 0, 0}, '{0, -4, 1}, '{0, 4, 1}, '{0, -5, 0},
                '{0, 5, 0}, '{1, 4, 1}, '{2, 4, 0}, '{-1, -4, 1}};

        rst = 1'b1; restart = 1'b0; mode = 2'd0;
        xCoord = 11'd5; yCoord = 11'd5;
        alien_xCoord = 11'd320; alien_yCoord = 11'd100; spaceship_xCoord = 11'd320;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reinit();
        m_lfsr = 8'hA5;
        @(negedge clk);
        chk("rst_lives", int'(lives), 3);
        chk("rst_is_bomb", int'(is_bomb), 0);
        chk("rst_ship_hit", int'(ship_hit), 0);
        chk("rst_ship_flash", int'(ship_flash), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rgb_bomb", int'(rgb_bomb), 8'h3F);

        // First launch after the fixed initial delay, then a hit on a centred ship
        run_until_model(S_FALL, 200, n);
        chk("first_launch_frame", n, 31);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            frame(2'd2);
            if (ship_flash) begin n = i; break; end
        end
        chk("hit_frame", n, 153);
        chk("lives_after_hit", int'(lives), 2);
        chk("hit_pulses", hits_seen, 1);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            frame(2'd2);
            if (!ship_flash) begin n = i; break; end
        end
        chk("flash_frames", n, 30);

        // Ship off to the side: bomb falls to the bottom and is lost
        spaceship_xCoord = 11'd100;
        run_until_model(S_FALL, 200, n);
        run_until_model(S_IDLE, 300, n);
        chk("miss_frames", n, 183);
        chk("lives_after_miss", int'(lives), 2);
        chk("miss_no_pulse", hits_seen, 1);

        // Restart, then three hits in a row drain the lives
        frame(2'd2, 1'b1);
        chk("restart_lives", int'(lives), 3);
        spaceship_xCoord = 11'd320;
        hits_seen = 0;
        n = -1;
        for (int i = 1; i <= 1000; i++) begin
            frame(2'd2);
            if (game_over) begin n = i; break; end
        end
        chk("game_over_reached", int'(n > 0), 1);
        chk("three_hits", hits_seen, 3);
        chk("lives_zero", int'(lives), 0);
        for (int i = 0; i < 150; i++) frame(2'd2);
        chk("over_no_more_hits", hits_seen, 3);
        chk("over_sticky", int'(game_over), 1);
        frame(2'd2, 1'b1);
        chk("restart_after_over_lives", int'(lives), 3);
        chk("restart_after_over_go", int'(game_over), 0);

        // No live alien: delay parks at zero, then launch on the very next tick
        alien_xCoord = 11'd0;
        for (int i = 0; i < 80; i++) frame(2'd2);
        alien_xCoord = 11'd200;
        frame(2'd2);
        cyc(200, 112);
        chk("launch_on_alien", int'(is_bomb), 1);

        // Pause mid-fall: bomb frozen, then boundary pixels from the table
        for (int i = 0; i < 20; i++) frame(2'd2);
        for (int i = 0; i < 50; i++) frame(2'd3);
        foreach (tbl[k]) begin
            cyc(m_bx + tbl[k].dx, m_by + tbl[k].dy);
            chk($sformatf("pix_tbl%0d", k), int'(is_bomb), int'(tbl[k].exp_bomb));
        end
        for (int i = 0; i < 5; i++) frame(2'd2);

        // Drop to menu mid-fall: bomb gone on the next clk
        cyc(m_bx, m_by);
        chk("pre_menu_bomb", int'(is_bomb), 1);
        @(posedge clk);
        #1 mode = 2'd1;
        @(negedge clk);
        chk("menu_same_clk", int'(is_bomb), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("menu_next_clk", int'(is_bomb), 0);
        model_step(2'd1, 1'b0);
        for (int i = 0; i < 3; i++) frame(2'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
